// File: rtl/fir_coef_loader.sv
// FIR coefficient loader: streams NUM_REGS words into a shadow bank, then
// commits them atomically to the active bank once the accelerator is idle.
module fir_coef_loader #(
  parameter  int NUM_REGS   = 8,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           loadStart,
  input  logic                           loadAbort,
  input  logic [DATA_WIDTH-1:0]          coefIn,
  input  logic                           coefValid,
  output logic                           coefReady,
  input  logic                           accelBusy,
  output logic [NUM_REGS*DATA_WIDTH-1:0] coefsFlat,
  output logic [IDX_W-1:0]               coefIdx,
  output logic                           loaderBusy,
  output logic                           loadDone,
  output logic                           bankValid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_COMMIT
  } state_t;

  state_t                           r_state;
  state_t                           w_next_state;
  logic [IDX_W-1:0]                 r_idx;
  logic [DATA_WIDTH-1:0]            r_shadow [NUM_REGS];
  logic [NUM_REGS*DATA_WIDTH-1:0]   r_active;
  logic                             r_load_done;
  logic                             r_bank_valid;
  logic                             w_beat;
  logic                             w_last_beat;
  logic                             w_commit;
  logic                             w_write_shadow;

  assign coefReady  = (r_state == S_LOAD);
  assign loaderBusy = (r_state != S_IDLE);
  assign coefsFlat  = r_active;
  assign coefIdx    = r_idx;
  assign loadDone   = r_load_done;
  assign bankValid  = r_bank_valid;

  // A beat coinciding with a start or abort pulse is dropped.
  assign w_beat         = coefValid && (r_state == S_LOAD);
  assign w_last_beat    = w_beat && (r_idx == IDX_W'(NUM_REGS - 1));
  assign w_write_shadow = w_beat && !loadStart && !loadAbort;
  assign w_commit       = (r_state == S_WAIT_COMMIT) && !accelBusy &&
                          !loadStart && !loadAbort;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (loadStart && !loadAbort) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (loadAbort)        w_next_state = S_IDLE;
        else if (loadStart)   w_next_state = S_LOAD;
        else if (w_last_beat) w_next_state = S_WAIT_COMMIT;
      end
      S_WAIT_COMMIT: begin
        if (loadAbort)       w_next_state = S_IDLE;
        else if (loadStart)  w_next_state = S_LOAD;
        else if (!accelBusy) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_active     <= '0;
      r_load_done  <= 1'b0;
      r_bank_valid <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
    end else begin
      r_state     <= w_next_state;
      r_load_done <= w_commit;
      if (loadStart || loadAbort) begin
        r_idx <= '0;
      end else if (w_beat) begin
        r_idx <= w_last_beat ? '0 : r_idx + IDX_W'(1);
      end
      if (w_write_shadow) r_shadow[r_idx] <= coefIn;
      // All taps move in the same edge so the filter never sees a mixed set.
      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++)
          r_active[i*DATA_WIDTH +: DATA_WIDTH] <= r_shadow[i];
        r_bank_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench for fir_coef_loader: a session-level model predicts
// committed sets; a monitor checks each loadDone against the queue.
module tb_fir_coef_loader;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int FW = N * DW;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          loadStart, loadAbort, coefValid, accelBusy;
  logic [DW-1:0] coefIn;
  logic          coefReady, loaderBusy, loadDone, bankValid;
  logic [FW-1:0] coefsFlat;
  logic [IW-1:0] coefIdx;

  fir_coef_loader #(.NUM_REGS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .loadStart(loadStart), .loadAbort(loadAbort),
    .coefIn(coefIn), .coefValid(coefValid), .coefReady(coefReady),
    .accelBusy(accelBusy), .coefsFlat(coefsFlat), .coefIdx(coefIdx),
    .loaderBusy(loaderBusy), .loadDone(loadDone), .bankValid(bankValid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Session model: words collected so far, whether a full set awaits commit.
  bit            m_open, m_pending, m_bank_valid;
  logic [DW-1:0] m_words [$];
  logic [DW-1:0] m_active [N];
  logic [FW-1:0] sb [$];

  function automatic logic [FW-1:0] flat_active();
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[i*DW +: DW] = m_active[i];
    return f;
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_pending = 0; m_bank_valid = 0;
    m_words.delete();
    for (int i = 0; i < N; i++) m_active[i] = '0;
  endtask

  task automatic step();
    @(negedge clk);
    chk("coefReady",  coefReady,  m_open);
    chk("loaderBusy", loaderBusy, m_open || m_pending);
    chk("coefIdx",    coefIdx,    m_open ? m_words.size() : 0);
    chk("coefsFlat",  coefsFlat,  flat_active());
    chk("bankValid",  bankValid,  m_bank_valid);
    @(posedge clk);
    if (loadAbort) begin
      m_open = 0; m_pending = 0; m_words.delete();
    end else if (loadStart) begin
      m_open = 1; m_pending = 0; m_words.delete();
    end else if (m_open && coefValid) begin
      m_words.push_back(coefIn);
      if (m_words.size() == N) begin m_open = 0; m_pending = 1; end
    end else if (m_pending && !accelBusy) begin
      for (int i = 0; i < N; i++) m_active[i] = m_words[i];
      m_bank_valid = 1; m_pending = 0;
      sb.push_back(flat_active());
    end
    #1;
    loadStart = 0; loadAbort = 0;
  endtask

  task automatic start_session();
    loadStart = 1; step();
  endtask

  task automatic beat(input logic [DW-1:0] d);
    coefValid = 1; coefIn = d; step();
    coefValid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every loadDone must match the oldest predicted commit.
  initial begin
    logic [FW-1:0] exp_set;
    forever begin
      @(negedge clk);
      if (loadDone) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL loadDone_spurious: got 1 expected 0 at %0t", $time);
        end else begin
          exp_set = sb.pop_front();
          chk("commit_set", coefsFlat, exp_set);
          chk("commit_bankValid", bankValid, 1'b1);
        end
      end else if (sb.size() != 0) begin
        n_checks++; n_fail++;
        $display("FAIL loadDone_missing: got 0 expected 1 at %0t", $time);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst = 0; loadStart = 0; loadAbort = 0; coefValid = 0; accelBusy = 0; coefIn = '0;
    model_reset();
    #2;
    chk("rst_coefsFlat", coefsFlat, '0);
    chk("rst_bankValid", bankValid, 1'b0);
    chk("rst_coefReady", coefReady, 1'b0);
    chk("rst_loaderBusy", loaderBusy, 1'b0);
    chk("rst_loadDone", loadDone, 1'b0);
    chk("rst_coefIdx", coefIdx, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    idle(2);

    // Back-to-back load 1..8, accelerator idle.
    start_session();
    for (int i = 0; i < N; i++) beat(DW'(i + 1));
    idle(3);

    // Commit held off by a busy accelerator for 20 cycles.
    accelBusy = 1;
    start_session();
    for (int i = 0; i < N; i++) beat($urandom);
    idle(20);
    accelBusy = 0;
    idle(3);

    // Commit an 0xA.. set, then abort a partial 0xFF load.
    start_session();
    for (int i = 0; i < N; i++) beat(DW'(32'hA0 + i));
    idle(2);
    start_session();
    for (int i = 0; i < 5; i++) beat(32'hFF);
    loadAbort = 1; step();
    idle(3);

    // Restart after 3 beats; the first beats are overwritten.
    start_session();
    for (int i = 0; i < 3; i++) beat(32'hDEAD_0000 + i);
    start_session();
    for (int i = 0; i < N; i++) beat(DW'(32'h10 + i));
    idle(2);

    // Start pulse coinciding with a beat drops it; abort+start: abort wins.
    start_session();
    beat(32'h1234);
    coefValid = 1; coefIn = 32'h5555; loadStart = 1; step();
    coefValid = 0;
    loadStart = 1; loadAbort = 1; step();
    idle(2);

    // Random 50% valid; extra beats past the set are refused while busy.
    accelBusy = 1;
    start_session();
    for (int c = 0; c < 200 && !m_pending; c++) begin
      coefValid = $urandom_range(0, 1); coefIn = $urandom; step();
    end
    coefValid = 1; coefIn = 32'h9999_9999;
    idle(4);
    coefValid = 0; accelBusy = 0;
    idle(3);

    // Random mixed traffic.
    for (int c = 0; c < 400; c++) begin
      loadStart = ($urandom_range(0, 19) == 0);
      loadAbort = ($urandom_range(0, 29) == 0);
      coefValid = $urandom_range(0, 1);
      coefIn    = $urandom;
      accelBusy = ($urandom_range(0, 2) == 0);
      step();
    end
    coefValid = 0; accelBusy = 0;
    idle(3);

    // Asynchronous reset while waiting for commit.
    start_session();
    for (int i = 0; i < N; i++) beat(DW'(32'h77 + i));
    idle(2);
    accelBusy = 1;
    start_session();
    for (int i = 0; i < N; i++) beat($urandom);
    idle(2);
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk("arst_coefsFlat", coefsFlat, '0);
    chk("arst_bankValid", bankValid, 1'b0);
    chk("arst_loaderBusy", loaderBusy, 1'b0);
    chk("arst_coefReady", coefReady, 1'b0);
    chk("arst_coefIdx", coefIdx, '0);
    model_reset();
    accelBusy = 0;
    @(posedge clk); #1;
    rst = 1;
    idle(3);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
Coefficient writer for the FIR accelerator on the CV32E40X. The core streams NUM_REGS coefficient words through a valid/ready handshake into a shadow bank. Once a full set has arrived and the accelerator is idle, the shadow bank is committed atomically to the active bank. The active bank drives the accelerator's parallel coefficient input, so the filter never computes with a partially written set.

Parameters:
- NUM_REGS, 8, number of taps (coefficients per set); must be ≥ 2.
- DATA_WIDTH, 32, width of one coefficient word.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- loadStart  input  1  one-cycle pulse; opens a load session
- loadAbort  input  1  one-cycle pulse; discards the current session
- coefIn  input  DATA_WIDTH  coefficient word from the core
- coefValid  input  1  coefIn valid
- coefReady  output  1  loader accepts a word this cycle
- accelBusy  input  1  accelerator mid-computation; commit is blocked while high
- coefsFlat  output  NUM_REGS*DATA_WIDTH  active bank; tap i at [i*DATA_WIDTH +: DATA_WIDTH]
- coefIdx  output  clog2(NUM_REGS)  index of the next shadow slot to be written
- loaderBusy  output  1  high in LOAD or WAIT_COMMIT
- loadDone  output  1  one-cycle pulse, coincident with the first cycle the new coefs appear
- bankValid  output  1  active bank holds at least one committed set

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - Shadow and active banks = 0; coefIdx = 0.
  - loadDone = 0, bankValid = 0, coefReady = 0, loaderBusy = 0.
- FSM states: IDLE, LOAD, WAIT_COMMIT.
- Decoded outputs: coefReady = (state==LOAD); loaderBusy = (state!=IDLE). Both are pure decodes of the state register.
- IDLE:
  - loadStart → LOAD, coefIdx <= 0.
  - coefValid is ignored (coefReady = 0).
- LOAD:
  - A beat transfers on a rising edge with coefValid && coefReady: shadow[coefIdx] <= coefIn, coefIdx++.
  - On the beat with coefIdx == NUM_REGS-1: coefIdx <= 0, state → WAIT_COMMIT. coefReady is low from the next cycle.
  - coefValid low: hold; no timeout.
- WAIT_COMMIT:
  - On an edge where accelBusy == 0: active <= shadow (all taps in the same edge), loadDone <= 1 for one cycle, bankValid <= 1, state → IDLE.
  - While accelBusy == 1: wait indefinitely; active bank unchanged.
- Latency: last beat accepted at edge N. With accelBusy low, commit happens at edge N+1, and the new coefsFlat and loadDone are visible in cycle N+1..N+2.
- Restart: loadStart in LOAD or WAIT_COMMIT restarts the session (state → LOAD, coefIdx <= 0). Shadow is overwritten in place and the active bank is untouched. A pending commit is cancelled.
- Abort: loadAbort in LOAD or WAIT_COMMIT → IDLE, coefIdx <= 0. Active bank, bankValid and shadow contents are retained; no loadDone. loadAbort in IDLE has no effect.
- Simultaneous events:
  - loadAbort and loadStart in the same cycle: abort wins → IDLE.
  - loadAbort with a handshake beat in the same cycle: the beat is dropped.
  - loadStart with a handshake beat in LOAD: the beat is dropped and coefIdx = 0.
  - WAIT_COMMIT with accelBusy low and loadAbort high: abort wins, no commit.
- Reset mid-session: everything returns to reset values, including the active bank (zeros) and bankValid = 0.
- coefsFlat is driven only from active-bank registers, never combinationally from coefIn.

Test Plan:
- Reset, then load 8 beats 0x1..0x8 back-to-back with accelBusy=0 → coefReady high for 8 cycles. Commit 1 cycle after the last beat; coefsFlat tap i = i+1; loadDone single pulse; bankValid=1.
- Load 8 beats with accelBusy=1 for 20 cycles after the last beat → coefsFlat holds the previous set and loaderBusy=1 throughout. Commit and loadDone occur on the first edge with accelBusy=0.
- Commit 0xA.. set, then load 5 beats of 0xFF, then loadAbort → state IDLE, coefsFlat still 0xA set, no loadDone, coefIdx=0.
- After 3 beats, pulse loadStart, then send 8 beats 0x10..0x17 → committed taps = 0x10..0x17; the first 3 beats are overwritten.
- Randomly toggle coefValid (50%) over a full load → exactly 8 transfers accepted in order; a 9th valid beat is not accepted (coefReady=0).
- Assert rst low in WAIT_COMMIT after a prior commit → coefsFlat = 0, bankValid = 0, loaderBusy = 0 immediately, without waiting for a clock edge.
